// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out serializer with a 2-word buffer (hold + shift register).
// Words arrive on a valid/ready handshake. The bits leave one per clock on op/op_valid.
module piso_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             op,
  output logic             op_valid,
  output logic             word_start,
  output logic             word_done
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [WIDTH-1:0]  hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              accept;
  logic              free;
  logic [WIDTH-1:0]  sreg_shifted;
  logic              out_bit;

  // Ready depends only on a register and reset, so no path from in_valid exists.
  assign in_ready = ~hold_full_q & ~reset;
  assign accept   = in_valid & in_ready;
  // The shift register can take a new word now: it is idle or is on its last bit.
  assign free     = (state_q == StIdle) | (cnt_q == LastCnt);

  assign sreg_shifted = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
  assign out_bit      = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];

  // Next-state: reload from hold or bypass when free, otherwise shift and fill hold.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    if (free) begin
      if (hold_full_q) begin
        sreg_d      = hold_q;
        hold_full_d = 1'b0;
        state_d     = StShift;
        cnt_d       = '0;
      end else if (accept) begin
        sreg_d  = in_data;
        state_d = StShift;
        cnt_d   = '0;
      end else begin
        state_d = StIdle;
      end
    end else begin
      sreg_d = sreg_shifted;
      cnt_d  = cnt_q + CntW'(1);
      if (accept) begin
        hold_d      = in_data;
        hold_full_d = 1'b1;
      end
    end
  end

  // State register with synchronous reset; any partial or held word is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

  // Serial outputs decode directly from registered state.
  always_comb begin
    op_valid   = (state_q == StShift);
    op         = op_valid ? out_bit : IDLE_BIT;
    word_start = op_valid & (cnt_q == '0);
    word_done  = op_valid & (cnt_q == LastCnt);
  end

endmodule
